// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control unit.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// shared multicycle datapath. Memory states wait on MemReady, so any number
// of wait states is absorbed. Also flags illegal opcodes (optionally trapping
// into a sticky HALT) and counts retired instructions.
module mc_control #(
  parameter int CNT_WIDTH       = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Op,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 BneBeq,
  output logic                 IsJAL,
  output logic                 ZeroExtend,
  output logic                 Illegal,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] Retired
);

  // Opcodes recognised by the decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUSrcB selections
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // ALUOp selections
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  // PCSource selections
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_RWB      = 4'd3,
    S_MEMADDR  = 4'd4,
    S_MEMREAD  = 4'd5,
    S_MEMWB    = 4'd6,
    S_MEMWRITE = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_retired;

  // Opcode class decodes; the IR is stable after FETCH so these are only
  // meaningful from DECODE onwards.
  logic w_is_rtype;
  logic w_is_mem;
  logic w_is_branch;
  logic w_is_imm;
  logic w_is_logic_imm;
  logic w_is_j;
  logic w_is_jal;
  logic w_is_known;
  logic w_retire;

  assign w_is_rtype     = (Op == OP_RTYPE);
  assign w_is_mem       = (Op == OP_LW)   || (Op == OP_SW);
  assign w_is_branch    = (Op == OP_BEQ)  || (Op == OP_BNE);
  assign w_is_logic_imm = (Op == OP_ANDI) || (Op == OP_ORI);
  assign w_is_imm       = (Op == OP_ADDI) || w_is_logic_imm;
  assign w_is_j         = (Op == OP_J);
  assign w_is_jal       = (Op == OP_JAL);
  assign w_is_known     = w_is_rtype | w_is_mem | w_is_branch | w_is_imm |
                          w_is_j | w_is_jal;

  // Next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_rtype)       w_next = S_EXEC_R;
        else if (w_is_mem)    w_next = S_MEMADDR;
        else if (w_is_branch) w_next = S_BRANCH;
        else if (w_is_imm)    w_next = S_EXEC_I;
        else if (w_is_j)      w_next = S_JUMP;
        else if (w_is_jal)    w_next = S_JAL;
        else if (TRAP_ON_ILLEGAL) w_next = S_HALT;
        else                  w_next = S_FETCH;
      end
      S_EXEC_R:   w_next = S_RWB;
      S_RWB:      w_next = S_FETCH;
      S_MEMADDR:  w_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (MemReady) w_next = S_FETCH;
      end
      S_BRANCH:   w_next = S_FETCH;
      S_EXEC_I:   w_next = S_IWB;
      S_IWB:      w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_JAL:      w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // An instruction retires when control returns to FETCH from a real
  // execution state; DECODE->FETCH is a discarded illegal opcode.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state != S_FETCH) &&
                    (r_state != S_DECODE) &&
                    (r_state != S_HALT);

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_ONE;
    end
  end

  assign Retired = r_retired;

  // Per-state control decode before the reset gate
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_bne_beq;
  logic       w_is_jal_out;
  logic       w_zero_ext;
  logic       w_illegal;
  logic       w_halted;

  // Moore decode of the state; only FETCH looks at MemReady so the IR and
  // PC are written exactly once, in the cycle the fetch completes.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_REG;
    w_alu_op        = ALU_ADD;
    w_pc_source     = PCS_ALU;
    w_bne_beq       = 1'b0;
    w_is_jal_out    = 1'b0;
    w_zero_ext      = 1'b0;
    w_illegal       = 1'b0;
    w_halted        = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = MemReady;
        w_pc_write  = MemReady;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        w_illegal   = ~w_is_known;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCS_ALUOUT;
        w_bne_beq       = Op[0];
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = w_is_logic_imm ? ALU_LOGI : ALU_ADD;
        w_zero_ext  = w_is_logic_imm;
      end
      S_IWB: begin
        // ALU result is still being written back, so keep its operation
        w_reg_write = 1'b1;
        w_alu_op    = w_is_logic_imm ? ALU_LOGI : ALU_ADD;
        w_zero_ext  = w_is_logic_imm;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCS_JUMP;
      end
      S_JAL: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCS_JUMP;
        w_reg_write  = 1'b1;
        w_is_jal_out = 1'b1;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_halted = 1'b0;
      end
    endcase
  end

  // Hold every control low while reset is asserted so nothing writes
  assign PCWrite     = rst_n & w_pc_write;
  assign PCWriteCond = rst_n & w_pc_write_cond;
  assign IorD        = rst_n & w_iord;
  assign MemRead     = rst_n & w_mem_read;
  assign MemWrite    = rst_n & w_mem_write;
  assign IRWrite     = rst_n & w_ir_write;
  assign MemtoReg    = rst_n & w_mem_to_reg;
  assign RegDst      = rst_n & w_reg_dst;
  assign RegWrite    = rst_n & w_reg_write;
  assign ALUSrcA     = rst_n & w_alu_src_a;
  assign ALUSrcB     = rst_n ? w_alu_src_b : 2'b00;
  assign ALUOp       = rst_n ? w_alu_op    : 2'b00;
  assign PCSource    = rst_n ? w_pc_source : 2'b00;
  assign BneBeq      = rst_n & w_bne_beq;
  assign IsJAL       = rst_n & w_is_jal_out;
  assign ZeroExtend  = rst_n & w_zero_ext;
  assign Illegal     = rst_n & w_illegal;
  assign Halted      = rst_n & w_halted;

endmodule
